// File: rtl/enc_dual.sv
// enc_dual: dual-channel one-hot encoder with a 3-state handshake FSM
// and an optional saturating error counter (define ENC_DUAL_ERR_CNT_EN).
module enc_dual (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       en1,
  input  logic       en2,
  input  logic       s,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] code,
  output logic       zero,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t     state;
  logic [3:0] w;
  logic [1:0] nc;
  logic       nz, ne;
  assign in_ready = state == IDLE;
  // multi-hot words report the highest set bit
  always_comb begin
    nc = w[3] ? 2'd3 : w[2] ? 2'd2 : w[1] ? 2'd1 : 2'd0;
    nz = w == 4'd0;
    ne = |(w & (w - 4'd1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      w         <= '0;
      code      <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          w     <= s ? (en2 ? b : 4'd0) : (en1 ? a : 4'd0);
          state <= CALC;
        end
        CALC: begin
          code      <= nc;
          zero      <= nz;
          err       <= ne;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          code      <= '0;
          zero      <= 1'b0;
          err       <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ENC_DUAL_ERR_CNT_EN
  logic [3:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (state == CALC && ne && cnt != 4'hf) cnt <= cnt + 4'd1;
  end
  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_enc_dual.sv
// tb_enc_dual: directed self-checking bench for enc_dual.
module tb_enc_dual;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       en1 = 1'b0, en2 = 1'b0, s = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, zero, err, out_valid;
  logic [1:0] code;
  logic [3:0] err_cnt;
  logic [3:0] ecnt = '0;
  int         checks = 0, errors = 0;
`ifdef ENC_DUAL_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  enc_dual dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en1(en1), .en2(en2), .s(s),
    .in_valid(in_valid), .in_ready(in_ready), .code(code), .zero(zero),
    .err(err), .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_chk(input string tag);
    chk({tag, "_cnt"}, {4'd0, err_cnt}, CNT_EN ? {4'd0, ecnt} : 8'd0);
  endtask

  task automatic do_req(input string tag, input logic sv, e1, e2, input logic [3:0] av, bv,
                        input logic [1:0] ec, input logic ez, ee);
    s = sv; en1 = e1; en2 = e2; a = av; b = bv; in_valid = 1'b1;
    chk({tag, "_inrdy"}, {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
    a = ~av; b = ~bv; s = ~sv;
    chk({tag, "_ov_early"}, {7'd0, out_valid}, 8'd0);
    step();
    if (ee && ecnt != 4'hf) ecnt = ecnt + 4'd1;
    chk({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_code"}, {6'd0, code}, {6'd0, ec});
    chk({tag, "_zero"}, {7'd0, zero}, {7'd0, ez});
    chk({tag, "_err"}, {7'd0, err}, {7'd0, ee});
    cnt_chk(tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, {7'd0, out_valid}, 8'd0);
    chk({tag, "_outs_clr"}, {4'd0, code, zero, err}, 8'd0);
  endtask

  initial begin
    logic [1:0] q[$];
    logic [3:0] pat [4];
    int acc, ovn;
    pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000;
    step(); step();
    chk("rst_ov", {7'd0, out_valid}, 8'd0);
    chk("rst_outs", {4'd0, code, zero, err}, 8'd0);
    chk("rst_inrdy", {7'd0, in_ready}, 8'd1);
    chk("rst_cnt", {4'd0, err_cnt}, 8'd0);
    rst_n = 1'b1;
    step();
    do_req("b0100", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b0);
    do_req("b_dis", 1'b1, 1'b1, 1'b0, 4'b1000, 4'b0100, 2'd0, 1'b1, 1'b0);
    do_req("a0001", 1'b0, 1'b1, 1'b1, 4'b0001, 4'b1000, 2'd0, 1'b0, 1'b0);
    do_req("a1000", 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
    do_req("b0010", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
    do_req("a_dis", 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 2'd0, 1'b1, 1'b0);
    do_req("a1010", 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000, 2'd3, 1'b0, 1'b1);
    do_req("b0110", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0110, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      do_req("sat", 1'b0, 1'b1, 1'b0, 4'b1010, 4'b0000, 2'd3, 1'b0, 1'b1);
    chk("sat_final", {4'd0, err_cnt}, CNT_EN ? 8'd15 : 8'd0);
    // stall in HOLD while inputs and in_valid churn
    s = 1'b0; en1 = 1'b1; a = 4'b0100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      a = a ^ 4'b1111; b = b ^ 4'b0101; s = ~s; in_valid = 1'b1;
      step();
      chk("hold_ov", {7'd0, out_valid}, 8'd1);
      chk("hold_code", {6'd0, code}, 8'd2);
      chk("hold_inrdy", {7'd0, in_ready}, 8'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rel_ov", {7'd0, out_valid}, 8'd0);
    chk("rel_inrdy", {7'd0, in_ready}, 8'd1);
    // continuous traffic: one accept per 3 cycles, results in order
    acc = 0; ovn = 0;
    s = 1'b0; en1 = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = pat[i % 4];
      if (in_ready) begin
        acc++;
        q.push_back(2'(i % 4));
      end
      step();
      if (out_valid) begin
        ovn++;
        if (q.size() > 0) chk("stream_code", {6'd0, code}, {6'd0, q.pop_front()});
        else chk("stream_extra", 8'd1, 8'd0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_acc", acc[7:0], 8'd10);
    chk("stream_ov", ovn[7:0], 8'd10);
    chk("stream_q", q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
    cnt_chk("stream");
    // reset while in CALC aborts the pending result
    s = 1'b0; en1 = 1'b1; a = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ecnt = '0;
    chk("abort_outs", {4'd0, code, zero, err}, 8'd0);
    chk("abort_inrdy", {7'd0, in_ready}, 8'd1);
    chk("abort_cnt", {4'd0, err_cnt}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_ov", {7'd0, out_valid}, 8'd0);
    end
    do_req("post", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1100, 2'd3, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enc_dual.md
ENC_DUAL -- requirements
Module: enc_dual

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 a  input  4  channel-0 one-hot word.
REQ-005 b  input  4  channel-1 one-hot word.
REQ-006 en1  input  1  channel-0 enable; 0 means channel-0 words are treated as all-zero.
REQ-007 en2  input  1  channel-1 enable; 0 means channel-1 words are treated as all-zero.
REQ-008 s  input  1  channel select; 0 selects a/en1, 1 selects b/en2.
REQ-009 in_valid  input  1  request to encode the currently selected word.
REQ-010 in_ready  output  1  block can accept a request this cycle.
REQ-011 code  output  2  encoded index of the selected word.
REQ-012 zero  output  1  selected word was all-zero or its channel was disabled.
REQ-013 err  output  1  selected word had more than one bit set.
REQ-014 out_valid  output  1  code/zero/err are valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 err_cnt  output  4  saturating count of results with err=1.

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC and HOLD; in_ready SHALL be 1 only in IDLE.
REQ-018 The block SHALL accept a request at edge N when it is in IDLE and in_valid=1. At that edge it SHALL capture w = s ? (en2 ? b : 0) : (en1 ? a : 0) and go to CALC.
REQ-019 Inputs a, b, en1, en2 and s SHALL be ignored outside the accepting edge; later changes SHALL NOT affect a pending result.
REQ-020 From CALC, the FSM SHALL go to HOLD at edge N+1, register code/zero/err and set out_valid=1. Latency is 2 cycles from accept to out_valid.
REQ-021 Encoding: 0001->00, 0010->01, 0100->10, 1000->11, with zero=0 and err=0.
REQ-022 An all-zero w SHALL give code=00, zero=1, err=0.
REQ-023 A w with two or more bits set SHALL give code = index of the highest set bit, with zero=0 and err=1 (e.g. 0110->10).
REQ-024 In HOLD, outputs SHALL stay stable while out_ready=0. With out_ready=1 at an edge, the FSM SHALL return to IDLE, clear out_valid and clear code/zero/err to 0.
REQ-025 out_ready SHALL be ignored when out_valid=0; in_valid SHALL be ignored outside IDLE, with no queuing.
REQ-026 The minimum request-to-request spacing SHALL be 3 cycles, and there SHALL be no back-to-back bypass.
REQ-027 err_cnt SHALL increment by 1 at the CALC->HOLD edge whenever err=1 is produced. It SHALL saturate at 15 and never wrap.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL set: state=IDLE, in_ready=1 (by state), out_valid=0, code=00, zero=0, err=0, err_cnt=0.
REQ-029 Reset in CALC or HOLD SHALL abort the pending result, which is never presented; only reset clears err_cnt.

Configuration
REQ-030 Macro ENC_DUAL_ERR_CNT_EN: when defined, err_cnt SHALL be implemented per REQ-027. When undefined, the counter register SHALL be absent and err_cnt SHALL be tied to 0; the err output is unaffected either way.

Verification
REQ-031 The bench SHALL cover: s=1, en2=1, b=0100, in_valid pulse -> out_valid 2 cycles later, code=10, zero=0, err=0.
REQ-032 The bench SHALL cover: s=1, en2=0, b=0100 -> code=00, zero=1, err=0; then s=0, en1=1, a=0001 -> code=00, zero=0.
REQ-033 The bench SHALL cover: s=0, en1=1, a=1010 -> code=11, err=1, err_cnt=1; 16 further such requests -> err_cnt holds at 15 (0 when the macro is undefined).
REQ-034 The bench SHALL cover: result in HOLD with out_ready=0 for 5 cycles while a, b and s toggle -> code/out_valid stable and in_ready=0; out_ready=1 -> out_valid=0 next cycle and in_ready=1.
REQ-035 The bench SHALL cover: in_valid held high continuously with out_ready=1 -> one accept every 3 cycles, no lost or duplicated results.
REQ-036 The bench SHALL cover: rst_n=0 for one edge while in CALC -> out_valid never asserts, all outputs are 0, in_ready=1, err_cnt=0.
